i2s_rx_deserializer: RTL and testbench
======================================

Name: i2s_rx_deserializer

Overview:
Front-end stage that recovers signed 16-bit PCM samples from an external I2S codec stream and feeds the IIR filter's `latest_sample` input. It oversamples the codec's serial lines (bit clock, frame clock, data) in the system clock domain and deserializes each channel slot. It delivers left/right words plus a once-per-frame valid strobe. Samples are Q2.14 raw two's-complement words; no scaling is applied.

Parameters:
DATA_WIDTH, 16, bits captured per channel slot (MSB first); extra slot bits are ignored.
SYNC_STAGES, 2, flip-flop depth of the input synchronizers (minimum 2).

Ports:
clk  input  1  system clock (100 MHz); must be >= 8x bclk frequency.
reset  input  1  asynchronous, active-low reset.
bclk  input  1  codec bit clock, asynchronous to clk.
l_r_clk  input  1  codec frame clock, asynchronous to clk; 0 = left slot, 1 = right slot.
sdata  input  1  codec serial data, changes on bclk falling edge.
left_sample  output  16  last complete left word, signed.
right_sample  output  16  last complete right word, signed.
latest_sample  output  16  copy of right_sample, wired to the IIR filter input.
sample_valid  output  1  one-clk pulse when a left+right pair has been updated.
frame_error  output  1  one-clk pulse when a slot ends with fewer than DATA_WIDTH bits.

Behaviour:
- Reset (reset=0, async): all outputs are 0, the synchronizers are cleared, the FSM is in IDLE, and bit_cnt is 0. Release takes effect on the next clk edge.
- Synchronizers: bclk, l_r_clk and sdata each pass through SYNC_STAGES FFs of identical depth. One more bclk register drives rising-edge detection (bclk_rise). All logic below advances only on clk cycles where bclk_rise=1.
- lrck_prev is the l_r_clk value registered at the previous bclk_rise. A frame transition occurs when the current synchronized l_r_clk differs from lrck_prev.
- I2S timing: the bit sampled at the transition edge belongs to the previous slot. The MSB of the new slot is sampled at the next bclk_rise.
- FSM states:
  - IDLE: ignore data. On a transition, go to SHIFT with chan = new l_r_clk and bit_cnt = 0.
  - SHIFT: on each bclk_rise without a transition, do shreg = {shreg[DATA_WIDTH-2:0], sdata} and bit_cnt++. When bit_cnt reaches DATA_WIDTH-1 on a shift, commit the word and go to HOLD.
  - HOLD: ignore extra slot bits (e.g. 32-bit slots). On a transition, go to SHIFT with the new chan and bit_cnt = 0.
  - Transition while in SHIFT (short slot): discard the partial word, pulse frame_error, restart SHIFT for the new channel.
- Commit (registered, on the clk after the final shift):
  - chan=0: left_sample <= word.
  - chan=1: right_sample and latest_sample <= word, and sample_valid pulses for exactly 1 clk.
  - The left commit never pulses sample_valid.
- sample_valid fires only after a right commit that follows a left commit in the same frame. The first right slot after IDLE (no preceding left) updates right_sample but does not pulse.
- Latency: from the raw bclk rising edge carrying the last captured bit to the sample_valid pulse is SYNC_STAGES+2 clk cycles (+1 for phase uncertainty). With defaults, this is 4-5 clks.
- Outputs hold their value between commits. left_sample is not cleared on a frame_error.
- Simultaneous events: a transition coinciding with the final shift counts as a transition. The word is incomplete, so frame_error pulses and no commit happens.
- Constant l_r_clk: the FSM stays in HOLD or IDLE indefinitely and no pulses are generated.
- Reset mid-slot: all state clears immediately and the FSM waits in IDLE for the next transition.

Test Plan:
- Reset held low with bclk toggling -> all outputs 0, no pulses. After release, the first right slot (no left yet) updates right_sample only, with no sample_valid.
- 32-bit slots, 3.072 MHz bclk, left=0x1234, right=0xA5C3 (extra 16 bits 0xFFFF) -> left_sample=0x1234, right_sample=latest_sample=0xA5C3, one sample_valid per frame, 4-5 clks after the right LSB edge.
- 16-bit slots (bclk = 32 x fs), left=0x8000, right=0x7FFF -> exact capture with no sign extension errors and no frame_error.
- Short slot: l_r_clk toggles after 10 right bits -> frame_error pulses 1 clk, right_sample keeps its prior value, and the next full frame captures correctly.
- reset asserted mid-left-slot, then released -> outputs 0 asynchronously, the partial word is discarded, and sample_valid first fires on the second frame after release.
- l_r_clk frozen for 1000 bclk cycles -> no sample_valid or frame_error, and outputs stable.

Source files
------------

// File: rtl/i2s_rx_deserializer.sv
// I2S receive deserializer.
// Oversamples the codec's bclk / l_r_clk / sdata in the clk domain, detects
// bclk rising edges and frame-clock transitions, and shifts each channel slot
// MSB first into a DATA_WIDTH word. Bits beyond DATA_WIDTH in a slot are
// ignored.
// Ports:
//   clk, reset      system clock, asynchronous active-low reset
//   bclk, l_r_clk   codec bit/frame clocks (async); l_r_clk 0 = left, 1 = right
//   sdata           codec serial data
//   left_sample     last complete left word
//   right_sample    last complete right word
//   latest_sample   copy of right_sample for the IIR filter input
//   sample_valid    1-clk pulse when a right word completes a left+right pair
//   frame_error     1-clk pulse when a slot ends before DATA_WIDTH bits arrived
module i2s_rx_deserializer #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bclk,
  input  logic                  l_r_clk,
  input  logic                  sdata,
  output logic [DATA_WIDTH-1:0] left_sample,
  output logic [DATA_WIDTH-1:0] right_sample,
  output logic [DATA_WIDTH-1:0] latest_sample,
  output logic                  sample_valid,
  output logic                  frame_error
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  logic [SYNC_STAGES-1:0] bclk_sync, lrck_sync, sdata_sync;
  logic                   bclk_s, lrck_s, sdata_s;
  logic                   bclk_d, bclk_rise, lrck_prev, lrck_edge;
  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       bit_cnt, cnt_nxt;
  logic                   chan, chan_nxt;
  logic                   do_shift, word_done, short_slot;
  logic                   left_ok;
  logic [DATA_WIDTH-1:0]  shreg;
  logic                   commit_pend, commit_chan, valid_pend, err_pend;

  // All three lines use the same synchronizer depth so that lrck/sdata are
  // aligned with the detected bclk edge.
  assign bclk_s    = bclk_sync[SYNC_STAGES-1];
  assign lrck_s    = lrck_sync[SYNC_STAGES-1];
  assign sdata_s   = sdata_sync[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_d;
  assign lrck_edge = bclk_rise & (lrck_s ^ lrck_prev);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bclk_sync  <= '0;
      lrck_sync  <= '0;
      sdata_sync <= '0;
      bclk_d     <= 1'b0;
    end else begin
      bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], bclk};
      lrck_sync  <= {lrck_sync[SYNC_STAGES-2:0], l_r_clk};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], sdata};
      bclk_d     <= bclk_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      chan    <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= cnt_nxt;
      chan    <= chan_nxt;
    end
  end

  // A frame transition always wins: the bit sampled on that edge belongs to
  // the previous slot, so it is never shifted, even if it would have been the
  // last one needed.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = bit_cnt;
    chan_nxt   = chan;
    do_shift   = 1'b0;
    word_done  = 1'b0;
    short_slot = 1'b0;
    if (lrck_edge) begin
      state_nxt  = SHIFT;
      cnt_nxt    = '0;
      chan_nxt   = lrck_s;
      short_slot = (state == SHIFT);
    end else if (bclk_rise && state == SHIFT) begin
      do_shift = 1'b1;
      cnt_nxt  = bit_cnt + 1'b1;
      if (bit_cnt == LAST_BIT) begin
        word_done = 1'b1;
        state_nxt = HOLD;
        cnt_nxt   = '0;
      end
    end
  end

  // left_ok remembers a completed left word in the current frame; only a
  // right word that follows it raises sample_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lrck_prev   <= 1'b0;
      shreg       <= '0;
      left_ok     <= 1'b0;
      commit_pend <= 1'b0;
      commit_chan <= 1'b0;
      valid_pend  <= 1'b0;
      err_pend    <= 1'b0;
    end else begin
      if (bclk_rise) lrck_prev <= lrck_s;
      if (do_shift)  shreg <= {shreg[DATA_WIDTH-2:0], sdata_s};
      if (short_slot || (lrck_edge && !lrck_s)) left_ok <= 1'b0;
      else if (word_done)                       left_ok <= ~chan;
      commit_pend <= word_done;
      commit_chan <= chan;
      valid_pend  <= word_done & chan & left_ok;
      err_pend    <= short_slot;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      left_sample  <= '0;
      right_sample <= '0;
      sample_valid <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      sample_valid <= valid_pend;
      frame_error  <= err_pend;
      if (commit_pend) begin
        if (commit_chan) right_sample <= shreg;
        else             left_sample  <= shreg;
      end
    end
  end

  assign latest_sample = right_sample;

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Bench for i2s_rx_deserializer. bclk/l_r_clk/sdata are launched just after
// a clk falling edge, so the raw-edge-to-output latency is exactly
// SYNC_STAGES+2 clks. A slot is sent as one framing rise (l_r_clk already
// switched, bit belongs to the previous slot) followed by nd data rises.
module tb_i2s_rx_deserializer;
  localparam int DW  = 16;
  localparam int SS  = 2;
  localparam int H   = 4;       // clk cycles per bclk half period (8x oversample)
  localparam int LAT = SS + 2;

  logic        clk = 1'b0, reset = 1'b0;
  logic        bclk = 1'b0, l_r_clk = 1'b0, sdata = 1'b0;
  logic [15:0] left_sample, right_sample, latest_sample;
  logic        sample_valid, frame_error;

  i2s_rx_deserializer #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .bclk(bclk), .l_r_clk(l_r_clk), .sdata(sdata),
    .left_sample(left_sample), .right_sample(right_sample),
    .latest_sample(latest_sample), .sample_valid(sample_valid),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 left commit, 1 right commit, 2 frame error
  typedef struct {
    int          due;
    int          kind;
    logic [15:0] word;
    bit          valid;
  } ev_t;
  ev_t evq[$];

  int vectors = 0, miscompares = 0;
  int val_cnt = 0, err_cnt = 0;
  logic [15:0] exp_l = '0, exp_r = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- behavioural model: slot-level bookkeeping from the framing rules ----
  bit m_prev = 0, m_open = 0, m_chan = 0, m_left_ok = 0;
  bit m_bits[$];

  task automatic model_clear();
    m_prev = 0; m_open = 0; m_chan = 0; m_left_ok = 0;
    m_bits.delete();
  endtask

  task automatic model_rise(input bit v, input bit b);
    ev_t e;
    logic [15:0] w;
    e.due = cyc + LAT; e.valid = 0; e.word = '0;
    if (v != m_prev) begin
      // slot boundary: an unfinished slot is an error
      if (m_open && m_bits.size() < DW) begin
        e.kind = 2; evq.push_back(e);
        m_left_ok = 0;
      end
      m_open = 1; m_chan = v; m_bits.delete();
      if (!v) m_left_ok = 0;
    end else if (m_open && m_bits.size() < DW) begin
      m_bits.push_back(b);
      if (m_bits.size() == DW) begin
        for (int i = 0; i < DW; i++) w[DW-1-i] = m_bits[i];
        e.kind = m_chan ? 1 : 0; e.word = w;
        e.valid = m_chan && m_left_ok;
        evq.push_back(e);
        m_left_ok = !m_chan;
      end
    end
    m_prev = v;
  endtask

  // ---- per-cycle compare ----
  initial begin
    ev_t ev;
    bit ev_v, ev_e;
    forever begin
      @(negedge clk);
      ev_v = 0; ev_e = 0;
      if (!reset) begin
        evq.delete(); exp_l = '0; exp_r = '0;
      end
      while (evq.size() > 0 && evq[0].due <= cyc) begin
        ev = evq.pop_front();
        case (ev.kind)
          0: exp_l = ev.word;
          1: begin exp_r = ev.word; ev_v = ev.valid; end
          default: ev_e = 1;
        endcase
      end
      chk("left_sample",   left_sample,   exp_l);
      chk("right_sample",  right_sample,  exp_r);
      chk("latest_sample", latest_sample, exp_r);
      chk("sample_valid",  sample_valid,  ev_v);
      chk("frame_error",   frame_error,   ev_e);
      if (sample_valid) val_cnt++;
      if (frame_error)  err_cnt++;
    end
  end

  // ---- stimulus ----
  task automatic wait_n(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic rise_bit(input bit v, input bit b);
    bclk = 0; l_r_clk = v; sdata = b;
    wait_n(H);
    bclk = 1;
    if (reset) model_rise(v, b);
    wait_n(H);
  endtask

  task automatic slot(input bit v, input int nd, input logic [15:0] w);
    rise_bit(v, 1'($urandom));
    for (int i = 0; i < nd; i++)
      rise_bit(v, (i < DW) ? w[DW-1-i] : 1'($urandom));
  endtask

  task automatic do_reset(input bit val);
    bclk = 0;
    wait_n(2);
    reset = val;
    if (!val) begin
      model_clear();
      #1;
      chk("async_rst_left",  left_sample,  0);
      chk("async_rst_right", right_sample, 0);
      chk("async_rst_valid", sample_valid, 0);
    end
  endtask

  initial begin
    int v0, e0;
    logic [15:0] w;
    bit ch;
    int nd;

    // reset held with the codec running
    wait_n(3);
    for (int k = 0; k < 6; k++) slot(k[0] ? 1'b0 : 1'b1, 15, 16'($urandom));
    chk("rst_left", left_sample, 0);
    chk("rst_valid_cnt", val_cnt, 0);
    do_reset(1);
    for (int k = 0; k < 6; k++) rise_bit(0, 1'($urandom));

    // first right slot after idle: no pulse
    slot(1, 31, 16'hBEEF);
    slot(0, 31, 16'h1234);
    chk("first_right", right_sample, 16'hBEEF);
    chk("first_right_nopulse", val_cnt, 0);
    slot(1, 31, 16'hA5C3);
    slot(0, 31, 16'h1234);
    chk("left_1234", left_sample, 16'h1234);
    chk("right_a5c3", right_sample, 16'hA5C3);
    chk("latest_a5c3", latest_sample, 16'hA5C3);
    chk("one_valid", val_cnt, 1);

    // minimum complete slots: DW data rises after the framing rise
    e0 = err_cnt;
    slot(1, 31, 16'h5A5A);
    slot(0, DW, 16'h8000);
    slot(1, DW, 16'h7FFF);
    slot(0, 31, 16'h0F0F);
    chk("left_8000_seen", val_cnt, 3);
    chk("right_7fff", right_sample, 16'h7FFF);
    chk("min_slot_no_err", err_cnt, e0);

    // last bit coinciding with the transition -> error, no commit
    slot(1, 31, 16'h1111);
    slot(0, DW-1, 16'h2222);
    v0 = val_cnt;
    slot(1, 31, 16'h3333);
    chk("coincide_err", err_cnt, e0 + 1);
    chk("coincide_left_kept", left_sample, 16'h0F0F);
    chk("coincide_no_valid", val_cnt, v0);

    // short right slot
    slot(0, 31, 16'h4444);
    slot(1, 10, 16'h5555);
    slot(0, 31, 16'h6666);
    chk("short_err", err_cnt, e0 + 2);
    chk("short_right_kept", right_sample, 16'h3333);
    slot(1, 31, 16'h7777);
    slot(0, 31, 16'h0000);
    chk("after_short_right", right_sample, 16'h7777);
    chk("after_short_valid", val_cnt, v0 + 1);

    // reset in the middle of a left slot
    slot(1, 31, 16'h9999);
    rise_bit(1, 0);
    rise_bit(0, 1'($urandom));
    for (int k = 0; k < 5; k++) rise_bit(0, 1'($urandom));
    do_reset(0);
    for (int k = 0; k < 4; k++) rise_bit(0, 1'($urandom));
    do_reset(1);
    v0 = val_cnt;
    for (int k = 0; k < 8; k++) rise_bit(0, 1'($urandom));
    slot(1, 31, 16'hCAFE);
    slot(0, 31, 16'hF00D);
    chk("post_rst_frame1_nopulse", val_cnt, v0);
    slot(1, 31, 16'hD00D);
    slot(0, 31, 16'h0001);
    chk("post_rst_frame2_pulse", val_cnt, v0 + 1);
    chk("post_rst_right", right_sample, 16'hD00D);

    // frozen frame clock: one right word then 1000+ quiet bclks
    e0 = err_cnt;
    slot(1, 1000, 16'h8001);
    chk("frozen_one_valid", val_cnt, v0 + 2);
    chk("frozen_no_err", err_cnt, e0);
    chk("frozen_right", right_sample, 16'h8001);

    // randomized frames, mostly 32-bit slots with occasional short ones
    ch = 0;
    for (int k = 0; k < 50; k++) begin
      nd = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 31) : 31;
      w  = 16'($urandom);
      slot(ch, nd, w);
      ch = !ch;
    end
    slot(ch, 31, 16'($urandom));
    wait_n(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
